// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundle of everything that passes between the 5-stage pipeline datapath and
// the hazard controller.
//   is_taken                           : EX-stage redirect (taken branch, jal, jalr)
//   instr_D/E/M/W        [31:0]        : instruction word held in each stage
//   pc_enable .. ME_WB_enable          : pipeline register update enables
//   IF_ID_flush .. ME_WB_flush         : bubble insertion into each register
//   fwd_a_sel/fwd_b_sel  [1:0]         : EX operand source (00 regfile, 01 MEM, 10 WB)
//   stall_cnt/flush_cnt  [31:0]        : performance counters
// Modports:
//   master : the pipeline side, drives instructions and redirect
//   slave  : the hazard controller, drives enables, flushes, selects, counters
interface hazard_ctrl_if;
  logic        is_taken;
  logic [31:0] instr_D;
  logic [31:0] instr_E;
  logic [31:0] instr_M;
  logic [31:0] instr_W;

  logic        pc_enable;
  logic        IF_ID_enable;
  logic        ID_EX_enable;
  logic        EX_ME_enable;
  logic        ME_WB_enable;

  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        EX_ME_flush;
  logic        ME_WB_flush;

  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;

  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output is_taken, instr_D, instr_E, instr_M, instr_W,
    input  pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable,
    input  IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  is_taken, instr_D, instr_E, instr_M, instr_W,
    output pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable,
    output IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard controller for a classic 5-stage RV32IM pipeline. Looks at the
// instruction words in ID/EX/MEM/WB and decides, every cycle, which pipeline
// registers update, which get a bubble, and where the EX operands come from.
// It also holds M-extension ops in EX for MUL_LAT cycles and counts stall and
// flush cycles.
// Parameters:
//   MUL_LAT : total EX occupancy of an M-extension op, 1..16
//   FWD_EN  : 1 = forward from MEM/WB, 0 = resolve every RAW by stalling
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : hazard_ctrl_if slave modport (instructions in, controls/counters out)
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int FWD_EN  = 1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] LOAD_CNT  = 4'(MUL_LAT - 1);
  localparam bit         MULTI_CYC = (MUL_LAT > 1);
  localparam bit         FWD_ON    = (FWD_EN != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;

  logic        w_redirect;
  logic        w_mopE;
  logic        w_loadUse;
  logic        w_rawE;
  logic        w_rawM;
  logic        w_rawW;
  logic        w_rawStall;
  logic        w_multiStall;

  logic        w_pcEnable;
  logic        w_ifIdEnable;
  logic        w_idExEnable;
  logic        w_exMeEnable;
  logic        w_meWbEnable;
  logic        w_ifIdFlush;
  logic        w_idExFlush;
  logic        w_exMeFlush;
  logic        w_meWbFlush;
  logic [1:0]  w_fwdA;
  logic [1:0]  w_fwdB;

  // An instruction only counts as a producer when its opcode writes a
  // register and rd is not x0; this also keeps x0 out of every hazard and
  // forwarding match without a separate check.
  function automatic logic writesRd(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    writesRd = ((op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
                (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
                (op == OP_JALR)) && (instr[11:7] != 5'd0);
  endfunction

  // Only lui, auipc and jal leave the rs1 field unused.
  function automatic logic readsRs1(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    readsRs1 = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  // R-type, stores and branches are the only formats with a real rs2.
  function automatic logic readsRs2(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    readsRs2 = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // True when the consumer actually reads the producer's destination.
  function automatic logic dependsOn(input logic [31:0] consumer,
                                     input logic [31:0] producer);
    dependsOn = writesRd(producer) &&
                ((readsRs1(consumer) && (consumer[19:15] == producer[11:7])) ||
                 (readsRs2(consumer) && (consumer[24:20] == producer[11:7])));
  endfunction

  // MEM is the youngest result so it wins over WB, but a load in MEM has no
  // data yet; in that case fall back to whatever WB can offer.
  function automatic logic [1:0] fwdSel(input logic [4:0]  rs,
                                        input logic [31:0] memInstr,
                                        input logic [31:0] wbInstr);
    if (writesRd(memInstr) && (memInstr[6:0] != OP_LOAD) && (memInstr[11:7] == rs))
      fwdSel = 2'b01;
    else if (writesRd(wbInstr) && (wbInstr[11:7] == rs))
      fwdSel = 2'b10;
    else
      fwdSel = 2'b00;
  endfunction

  // Hazard detection. A redirect needs a control-transfer opcode in EX, not
  // just is_taken. With forwarding only a load feeding ID must stall; without
  // it any producer still in flight blocks the instruction in ID.
  assign w_redirect = bus.is_taken &&
                      ((bus.instr_E[6:0] == OP_BRANCH) ||
                       (bus.instr_E[6:0] == OP_JAL) ||
                       (bus.instr_E[6:0] == OP_JALR));
  assign w_mopE     = (bus.instr_E[6:0] == OP_R) && (bus.instr_E[31:25] == F7_MULDIV);
  assign w_loadUse  = (bus.instr_E[6:0] == OP_LOAD) && dependsOn(bus.instr_D, bus.instr_E);
  assign w_rawE     = dependsOn(bus.instr_D, bus.instr_E);
  assign w_rawM     = dependsOn(bus.instr_D, bus.instr_M);
  assign w_rawW     = dependsOn(bus.instr_D, bus.instr_W);
  assign w_rawStall = FWD_ON ? w_loadUse : (w_rawE || w_rawM || w_rawW);

  // The M-op stall is active on the detection cycle in IDLE and on every BUSY
  // cycle except the last, so the op sits in EX for exactly MUL_LAT cycles.
  assign w_multiStall = ((r_state == IDLE) && w_mopE && MULTI_CYC) ||
                        ((r_state == BUSY) && (r_cnt != 4'd1));

  // Multi-cycle sequencer. Entering BUSY loads the number of cycles left after
  // the detection cycle; the count reaching 1 marks the release cycle. Reset
  // drops any op in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mopE && MULTI_CYC) begin
            r_state <= BUSY;
            r_cnt   <= LOAD_CNT;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd1) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Pipeline control, strongest cause first: reset bubbles every stage, a
  // redirect squashes the two wrong-path instructions behind EX, an M-op
  // freezes IF/ID/EX and bubbles MEM, and a RAW stall freezes IF/ID and
  // bubbles EX.
  always_comb begin
    w_pcEnable   = 1'b1;
    w_ifIdEnable = 1'b1;
    w_idExEnable = 1'b1;
    w_exMeEnable = 1'b1;
    w_meWbEnable = 1'b1;
    w_ifIdFlush  = 1'b0;
    w_idExFlush  = 1'b0;
    w_exMeFlush  = 1'b0;
    w_meWbFlush  = 1'b0;
    if (rst) begin
      w_ifIdFlush = 1'b1;
      w_idExFlush = 1'b1;
      w_exMeFlush = 1'b1;
      w_meWbFlush = 1'b1;
    end else if (w_redirect) begin
      w_ifIdFlush = 1'b1;
      w_idExFlush = 1'b1;
    end else if (w_multiStall) begin
      w_pcEnable   = 1'b0;
      w_ifIdEnable = 1'b0;
      w_idExEnable = 1'b0;
      w_exMeFlush  = 1'b1;
    end else if (w_rawStall) begin
      w_pcEnable   = 1'b0;
      w_ifIdEnable = 1'b0;
      w_idExFlush  = 1'b1;
    end
  end

  // Operand source selects for the instruction in EX; held at the register
  // file when forwarding is disabled or the block is in reset.
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (!rst && FWD_ON) begin
      w_fwdA = fwdSel(bus.instr_E[19:15], bus.instr_M, bus.instr_W);
      w_fwdB = fwdSel(bus.instr_E[24:20], bus.instr_M, bus.instr_W);
    end
  end

  // Performance counters sample the final control values, so a cycle counts
  // as a stall only if the PC really held, and as a flush only if IF/ID was
  // really squashed. Both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= 32'd0;
      r_flushCnt <= 32'd0;
    end else begin
      r_stallCnt <= r_stallCnt + {31'd0, ~w_pcEnable};
      r_flushCnt <= r_flushCnt + {31'd0, w_ifIdFlush};
    end
  end

  assign bus.pc_enable    = w_pcEnable;
  assign bus.IF_ID_enable = w_ifIdEnable;
  assign bus.ID_EX_enable = w_idExEnable;
  assign bus.EX_ME_enable = w_exMeEnable;
  assign bus.ME_WB_enable = w_meWbEnable;
  assign bus.IF_ID_flush  = w_ifIdFlush;
  assign bus.ID_EX_flush  = w_idExFlush;
  assign bus.EX_ME_flush  = w_exMeFlush;
  assign bus.ME_WB_flush  = w_meWbFlush;
  assign bus.fwd_a_sel    = w_fwdA;
  assign bus.fwd_b_sel    = w_fwdB;
  assign bus.stall_cnt    = r_stallCnt;
  assign bus.flush_cnt    = r_flushCnt;

endmodule
